// File: rtl/wb_intercon.sv
// Single-master, 17-slave shared-bus interconnect.
// Decodes, broadcasts, muxes read data and times out silent slaves.
module wb_intercon #(
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          master_STB,
   input  logic          master_WE,
   input  logic [31:0]   master_ADDR,
   input  logic [31:0]   master_DAT_I,
   output logic [31:0]   master_DAT_O,
   output logic          master_ACK,
   output logic [16:0]   slave_STB,
   input  logic [16:0]   slave_ACK,
   output logic          slave_WE,
   input  logic [511:0]  slave_DAT_I,
   output logic [31:0]   slave_DAT_O,
   output logic [31:0]   slave_ADDR,
   input  logic          err_clr,
   output logic          bus_err,
   output logic [31:0]   err_addr
);

   localparam int NSLV = 17;
   localparam int NLANE = 16;
   localparam int CLOG = $clog2(TIMEOUT + 1);
   localparam int CW = (CLOG > 8) ? CLOG : 8;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   logic [4:0]    idx;
   logic          mapped;
   logic          hit_ack;
   logic          sel_ack;
   logic          err_ack;
   logic [31:0]   lane;
   logic [CW-1:0] wait_cnt;
   logic          cnt_clr;

   assign idx = master_ADDR[31:27];
   assign mapped = (idx <= 5'd16);

   assign slave_ADDR = master_ADDR;
   assign slave_DAT_O = master_DAT_I;
   assign slave_WE = master_WE;

   // One-hot strobe decode; nothing strobes on an unmapped address
   always_comb begin
      slave_STB = '0;
      for (int k = 0; k < NSLV; k++) begin
         slave_STB[k] = master_STB & (idx == 5'(k));
      end
   end

   // Only the addressed slave's ACK is looked at
   always_comb begin
      hit_ack = 1'b0;
      for (int k = 0; k < NSLV; k++) begin
         hit_ack = hit_ack | (slave_ACK[k] & (idx == 5'(k)));
      end
   end

   // Read lane select; slave 16 and unmapped space have no lane
   always_comb begin
      lane = '0;
      for (int k = 0; k < NLANE; k++) begin
         if (idx == 5'(k)) begin
            lane = slave_DAT_I[k*32 +: 32];
         end
      end
   end

   assign sel_ack = master_STB & hit_ack;

   assign err_ack = master_STB & ~sel_ack &
                    ((~mapped & (wait_cnt >= CW'(1))) |
                     (mapped & (wait_cnt == TMAX)));

   assign master_ACK = sel_ack | err_ack;
   assign master_DAT_O = err_ack ? ERR_DATA : lane;

   assign cnt_clr = ~master_STB | master_ACK;

   // Watchdog: counts wait cycles of the current request, saturating
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wait_cnt <= '0;
      end else if (cnt_clr) begin
         wait_cnt <= '0;
      end else if (wait_cnt != TMAX) begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end

   // Sticky error status; a new error beats a simultaneous clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus_err <= 1'b0;
         err_addr <= '0;
      end else if (err_ack) begin
         bus_err <= 1'b1;
         if (!bus_err || err_clr) begin
            err_addr <= master_ADDR;
         end
      end else if (err_clr) begin
         bus_err <= 1'b0;
         err_addr <= '0;
      end
   end

endmodule

// File: tb/tb_wb_intercon.sv
// Self-checking bench for wb_intercon: vector table plus
// hand-written multi-cycle sequences, all through a scoreboard.
module tb_wb_intercon;

   localparam int TO = 4;
   localparam logic [31:0] ED = 32'hDEAD_BEEF;

   logic          clk;
   logic          rstn;
   logic          master_STB;
   logic          master_WE;
   logic [31:0]   master_ADDR;
   logic [31:0]   master_DAT_I;
   logic [31:0]   master_DAT_O;
   logic          master_ACK;
   logic [16:0]   slave_STB;
   logic [16:0]   slave_ACK;
   logic          slave_WE;
   logic [511:0]  slave_DAT_I;
   logic [31:0]   slave_DAT_O;
   logic [31:0]   slave_ADDR;
   logic          err_clr;
   logic          bus_err;
   logic [31:0]   err_addr;

   wb_intercon #(.TIMEOUT(TO), .ERR_DATA(ED)) dut (
      .clk(clk),
      .rstn(rstn),
      .master_STB(master_STB),
      .master_WE(master_WE),
      .master_ADDR(master_ADDR),
      .master_DAT_I(master_DAT_I),
      .master_DAT_O(master_DAT_O),
      .master_ACK(master_ACK),
      .slave_STB(slave_STB),
      .slave_ACK(slave_ACK),
      .slave_WE(slave_WE),
      .slave_DAT_I(slave_DAT_I),
      .slave_DAT_O(slave_DAT_O),
      .slave_ADDR(slave_ADDR),
      .err_clr(err_clr),
      .bus_err(bus_err),
      .err_addr(err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [16:0] stb;
      logic        ack;
      logic [31:0] dat;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdat;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        stb;
      logic        we;
      logic [16:0] sack;
      logic [16:0] e_stb;
      logic        e_ack;
      logic [31:0] e_dat;
   } vec_t;

   exp_t sb[$];
   int passed = 0;
   int total = 0;

   function automatic logic [31:0] word(int k);
      if (k == 2) return 32'h1234_5678;
      return 32'h0101_0101 * 32'(k + 1);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic push(string nm, logic [16:0] s, logic a,
                       logic [31:0] d);
      exp_t e;
      e.nm = nm;
      e.stb = s;
      e.ack = a;
      e.dat = d;
      e.addr = master_ADDR;
      e.we = master_WE;
      e.wdat = master_DAT_I;
      sb.push_back(e);
   endtask

   task automatic pop_cmp();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         $display("FAIL scoreboard: empty queue");
         return;
      end
      e = sb.pop_front();
      chk({e.nm, ".stb"}, 32'(slave_STB), 32'(e.stb));
      chk({e.nm, ".ack"}, 32'(master_ACK), 32'(e.ack));
      if (e.ack || !master_STB)
         chk({e.nm, ".dat"}, master_DAT_O, e.dat);
      chk({e.nm, ".bcast"},
          {slave_ADDR[31:1], slave_WE} ^ slave_DAT_O,
          {e.addr[31:1], e.we} ^ e.wdat);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(string nm, logic [16:0] sack, logic [16:0] es,
                      logic ea, logic [31:0] ed);
      slave_ACK = sack;
      push(nm, es, ea, ed);
      @(negedge clk);
      pop_cmp();
      tick();
   endtask

   task automatic start(logic [31:0] a, logic we, logic [31:0] wd);
      master_ADDR = a;
      master_WE = we;
      master_DAT_I = wd;
      master_STB = 1'b1;
   endtask

   task automatic idle();
      master_STB = 1'b0;
      slave_ACK = '0;
      err_clr = 1'b0;
      tick();
   endtask

   vec_t vt[7];

   initial begin
      rstn = 1'b0;
      master_STB = 1'b0;
      master_WE = 1'b0;
      master_ADDR = '0;
      master_DAT_I = '0;
      slave_ACK = '0;
      err_clr = 1'b0;
      for (int k = 0; k < 16; k++) slave_DAT_I[k*32 +: 32] = word(k);

      vt[0] = '{32'h1000_0004, 1'b1, 1'b0, 17'h00004,
                17'h00004, 1'b1, word(2)};
      vt[1] = '{32'h2000_0000, 1'b1, 1'b1, 17'h00010,
                17'h00010, 1'b1, word(4)};
      vt[2] = '{32'h8000_0000, 1'b1, 1'b0, 17'h10000,
                17'h10000, 1'b1, 32'h0};
      vt[3] = '{32'h0800_0000, 1'b1, 1'b0, 17'h00004,
                17'h00002, 1'b0, word(1)};
      vt[4] = '{32'hF800_0000, 1'b1, 1'b0, 17'h1FFFF,
                17'h00000, 1'b0, 32'h0};
      vt[5] = '{32'h1000_0000, 1'b0, 1'b0, 17'h00004,
                17'h00000, 1'b0, word(2)};
      vt[6] = '{32'h7800_0000, 1'b1, 1'b1, 17'h08000,
                17'h08000, 1'b1, word(15)};

      #12;
      chk("rst.bus_err", 32'(bus_err), 32'h0);
      chk("rst.err_addr", err_addr, 32'h0);
      chk("rst.stb", 32'(slave_STB), 32'h0);
      chk("rst.ack", 32'(master_ACK), 32'h0);
      tick();
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         master_ADDR = vt[i].addr;
         master_STB = vt[i].stb;
         master_WE = vt[i].we;
         master_DAT_I = 32'hCAFE_F00D ^ 32'(i);
         cyc($sformatf("vec%0d", i), vt[i].sack, vt[i].e_stb,
             vt[i].e_ack, vt[i].e_dat);
         idle();
      end
      chk("vec.no_err", 32'(bus_err), 32'h0);

      start(32'h1000_0004, 1'b0, 32'h0);
      cyc("rd.c1", 17'h0, 17'h4, 1'b0, 32'h0);
      cyc("rd.c2", 17'h0, 17'h4, 1'b0, 32'h0);
      cyc("rd.c3", 17'h4, 17'h4, 1'b1, 32'h1234_5678);
      idle();
      chk("rd.bus_err", 32'(bus_err), 32'h0);

      start(32'hF800_0000, 1'b0, 32'h0);
      cyc("um.c1", 17'h0, 17'h0, 1'b0, 32'h0);
      cyc("um.c2", 17'h0, 17'h0, 1'b1, ED);
      idle();
      chk("um.bus_err", 32'(bus_err), 32'h1);
      chk("um.err_addr", err_addr, 32'hF800_0000);

      start(32'hA000_0000, 1'b1, 32'h5);
      cyc("um2.c1", 17'h0, 17'h0, 1'b0, 32'h0);
      cyc("um2.c2", 17'h0, 17'h0, 1'b1, ED);
      idle();
      chk("um2.err_addr", err_addr, 32'hF800_0000);

      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr.bus_err", 32'(bus_err), 32'h0);
      chk("clr.err_addr", err_addr, 32'h0);

      start(32'h0000_0100, 1'b0, 32'h0);
      cyc("to.c1", 17'h0, 17'h1, 1'b0, 32'h0);
      cyc("to.c2", 17'h8, 17'h1, 1'b0, 32'h0);
      cyc("to.c3", 17'h0, 17'h1, 1'b0, 32'h0);
      cyc("to.c4", 17'h0, 17'h1, 1'b0, 32'h0);
      cyc("to.c5", 17'h0, 17'h1, 1'b1, ED);
      idle();
      chk("to.bus_err", 32'(bus_err), 32'h1);
      chk("to.err_addr", err_addr, 32'h0000_0100);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("to.clr", 32'(bus_err), 32'h0);

      start(32'h0800_0000, 1'b0, 32'h0);
      for (int c = 1; c <= 4; c++)
         cyc($sformatf("tie.c%0d", c), 17'h0, 17'h2, 1'b0, 32'h0);
      cyc("tie.c5", 17'h2, 17'h2, 1'b1, word(1));
      idle();
      chk("tie.bus_err", 32'(bus_err), 32'h0);

      start(32'h1800_0000, 1'b0, 32'h0);
      for (int c = 1; c <= 3; c++)
         cyc($sformatf("ab.c%0d", c), 17'h0, 17'h8, 1'b0, 32'h0);
      master_STB = 1'b0;
      cyc("ab.drop", 17'h0, 17'h0, 1'b0, word(3));
      master_STB = 1'b1;
      for (int c = 1; c <= 4; c++)
         cyc($sformatf("ab.r%0d", c), 17'h0, 17'h8, 1'b0, 32'h0);
      cyc("ab.r5", 17'h8, 17'h8, 1'b1, word(3));
      idle();
      chk("ab.bus_err", 32'(bus_err), 32'h0);

      start(32'hF800_0000, 1'b0, 32'h0);
      cyc("ce.a1", 17'h0, 17'h0, 1'b0, 32'h0);
      cyc("ce.a2", 17'h0, 17'h0, 1'b1, ED);
      idle();
      start(32'hC000_0000, 1'b0, 32'h0);
      cyc("ce.b1", 17'h0, 17'h0, 1'b0, 32'h0);
      err_clr = 1'b1;
      cyc("ce.b2", 17'h0, 17'h0, 1'b1, ED);
      idle();
      chk("ce.bus_err", 32'(bus_err), 32'h1);
      chk("ce.err_addr", err_addr, 32'hC000_0000);

      start(32'h0000_0200, 1'b0, 32'h0);
      for (int c = 1; c <= 3; c++)
         cyc($sformatf("rs.c%0d", c), 17'h0, 17'h1, 1'b0, 32'h0);
      #2;
      rstn = 1'b0;
      #1;
      chk("rs.bus_err", 32'(bus_err), 32'h0);
      chk("rs.err_addr", err_addr, 32'h0);
      tick();
      rstn = 1'b1;
      for (int c = 1; c <= 4; c++)
         cyc($sformatf("rs.r%0d", c), 17'h0, 17'h1, 1'b0, 32'h0);
      cyc("rs.r5", 17'h0, 17'h1, 1'b1, ED);
      idle();
      chk("rs.err_addr2", err_addr, 32'h0000_0200);

      total++;
      if (sb.size() == 0) passed++;
      else $display("FAIL scoreboard.left: got %0d want 0", sb.size());

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
